// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with flush, conditional write and kill.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W   = 64,
  parameter int CTRL_W   = 8,
  parameter int COND_IDX = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_flush,
  input  logic              in_cond_en,
  input  logic              in_cond_pass,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  localparam logic [CTRL_W-1:0] COND_MASK = CTRL_W'(1) << COND_IDX;
  logic [1:0] occ_q, occ_d;
  logic [CTRL_W-1:0] ctrl0_q, ctrl0_d, new_ctrl, nxt_ctrl;
  logic [DATA_W-1:0] data0_q, data0_d, nxt_data;
  logic acc, pop, shift, take_new;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = occ_q != 2'd0;
  assign out_ctrl = out_valid ? ctrl0_q : '0;
  assign out_data = data0_q;
  assign occupancy = occ_q;
  always_comb begin
    new_ctrl = in_flush ? '0 : (in_cond_en & ~in_cond_pass) ? (in_ctrl & ~COND_MASK) : in_ctrl;
    take_new = acc & ((occ_q == 2'd0) | ((occ_q == 2'd1) & pop));
    ctrl0_d = take_new ? new_ctrl : shift ? nxt_ctrl : (pop | kill) ? '0 : ctrl0_q;
    data0_d = take_new ? in_data : shift ? nxt_data : data0_q;
    occ_d = occ_q + {1'b0, acc} - {1'b0, pop};
  end
`ifdef PIPE_STAGE_SKID_EN
  logic rdy_q, ld1;
  logic [CTRL_W-1:0] ctrl1_q, ctrl1_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  assign in_ready = rdy_q;
  assign shift = pop & (occ_q == 2'd2);
  assign ld1 = acc & (occ_q == 2'd1) & ~pop;
  assign nxt_ctrl = kill ? '0 : ctrl1_q;
  assign nxt_data = data1_q;
  assign ctrl1_d = ld1 ? new_ctrl : (shift | kill) ? '0 : ctrl1_q;
  assign data1_d = ld1 ? in_data : data1_q;
  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b1;
      ctrl1_q <= '0;
      data1_q <= '0;
    end else begin
      rdy_q <= occ_d != 2'd2;
      ctrl1_q <= ctrl1_d;
      data1_q <= data1_d;
    end
  end
`else
  assign in_ready = (occ_q == 2'd0) | out_ready;
  assign shift = 1'b0;
  assign nxt_ctrl = '0;
  assign nxt_data = data0_q;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      ctrl0_q <= '0;
      data0_q <= '0;
    end else begin
      occ_q <= occ_d;
      ctrl0_q <= ctrl0_d;
      data0_q <= data0_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg, either buffering mode.
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int CI = 0;
  localparam int VW = CW + DW + 4;
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_flush = 1'b0, in_cond_en = 1'b0, in_cond_pass = 1'b0;
  logic kill = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0] occupancy;
  ent_t sb[$];
  ent_t got[$];
  logic [DW-1:0] last_d = '0;
  int vectors = 0, errors = 0;
  logic [VW-1:0] dut_vec;
  assign dut_vec = {out_valid, out_ctrl, out_data, occupancy, in_ready};

  pipe_stage_reg dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_flush(in_flush), .in_cond_en(in_cond_en), .in_cond_pass(in_cond_pass),
    .in_ctrl(in_ctrl), .in_data(in_data), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic mdl_rdy();
`ifdef PIPE_STAGE_SKID_EN
    return sb.size() < 2;
`else
    return sb.size() == 0 || out_ready;
`endif
  endfunction

  function automatic logic [CW-1:0] mdl_ctrl();
    logic [CW-1:0] c;
    c = in_ctrl;
    if (in_flush) c = '0;
    else if (in_cond_en && !in_cond_pass) c[CI] = 1'b0;
    return c;
  endfunction

  function automatic logic [VW-1:0] mdl_out();
    if (sb.size() == 0) return {1'b0, {CW{1'b0}}, last_d, 2'd0, mdl_rdy()};
    return {1'b1, sb[0].c, sb[0].d, 2'(sb.size()), mdl_rdy()};
  endfunction

  // advances one clock and applies accept/pop/kill to the scoreboard
  task automatic tick();
    logic a, p;
    ent_t e;
    a = in_valid && mdl_rdy();
    p = sb.size() > 0 && out_ready;
    e.c = mdl_ctrl();
    e.d = in_data;
    if (out_valid && out_ready) got.push_back({out_ctrl, out_data});
    @(posedge clock);
    if (kill) foreach (sb[i]) sb[i].c = '0;
    if (p) begin
      last_d = sb[0].d;
      void'(sb.pop_front());
    end
    if (a) sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_flush = 1'b0; in_cond_en = 1'b0; in_cond_pass = 1'b0; kill = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({out_valid, occupancy, out_ctrl, out_data, in_ready} !== {1'b0, 2'd0, {CW{1'b0}}, {DW{1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got %h exp all-zero with in_ready=1", {out_valid, occupancy, out_ctrl, out_data, in_ready});
    end
    in_valid = 1'b1; in_ctrl = 8'h77; in_data = 64'h77;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({out_valid, occupancy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ignores_input: got %b exp 000", {out_valid, occupancy});
    end
    idle();
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b exp 1", in_ready);
    end
    tick();
    vectors++;
    if (dut_vec !== mdl_out()) begin
      errors++;
      $display("FAIL idle_after_reset: got %h exp %h", dut_vec, mdl_out());
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 64'h1234;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b1, 8'h5A, 64'h1234, 2'd1}) begin
      errors++;
      $display("FAIL basic_out: got %h exp %h", {out_valid, out_ctrl, out_data, occupancy}, {1'b1, 8'h5A, 64'h1234, 2'd1});
    end
    tick();
    vectors++;
    if ({out_valid, out_ctrl, out_data, occupancy} !== {1'b0, 8'h00, 64'h1234, 2'd0}) begin
      errors++;
      $display("FAIL basic_drain: got %h exp %h", {out_valid, out_ctrl, out_data, occupancy}, {1'b0, 8'h00, 64'h1234, 2'd0});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_flush = 1'b1; in_ctrl = 8'hFF; in_data = 64'hBEEF;
    tick();
    idle();
    #1;
    vectors++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h00, 64'hBEEF}) begin
      errors++;
      $display("FAIL flush_out: got %h exp %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'h00, 64'hBEEF});
    end
    tick();
  endtask

  task automatic test_cond();
    out_ready = 1'b1; in_valid = 1'b1; in_cond_en = 1'b1; in_cond_pass = 1'b0; in_ctrl = 8'h03; in_data = 64'hC0;
    tick();
    in_cond_pass = 1'b1; in_data = 64'hC1;
    #1;
    vectors++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h02, 64'hC0}) begin
      errors++;
      $display("FAIL cond_fail_out: got %h exp %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'h02, 64'hC0});
    end
    tick();
    idle();
    #1;
    vectors++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h03, 64'hC1}) begin
      errors++;
      $display("FAIL cond_pass_out: got %h exp %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'h03, 64'hC1});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] cs[3];
    int k;
    cs[0] = 8'hA1; cs[1] = 8'hB2; cs[2] = 8'hC3;
    k = 0;
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 16 && (k < 3 || sb.size() > 0); i++) begin
      if (i == 4) out_ready = 1'b1;
      in_valid = k < 3;
      in_ctrl = (k < 3) ? cs[k] : 8'h00;
      in_data = 64'(k) + 64'h100;
      #1;
      if (i == 4) begin
        vectors++;
`ifdef PIPE_STAGE_SKID_EN
        if ({occupancy, in_ready} !== {2'd2, 1'b0}) begin
          errors++;
          $display("FAIL hold_full: got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready);
        end
`else
        if ({occupancy, out_ctrl} !== {2'd1, 8'hA1}) begin
          errors++;
          $display("FAIL hold_full: got occ=%0d ctrl=%h exp occ=1 ctrl=a1", occupancy, out_ctrl);
        end
`endif
      end
      vectors++;
      if (dut_vec !== mdl_out()) begin
        errors++;
        $display("FAIL backpressure[%0d]: got %h exp %h", i, dut_vec, mdl_out());
      end
      if (in_valid && mdl_rdy()) k++;
      tick();
    end
    idle();
    vectors++;
    if (got.size() != 3 || got[0].c !== 8'hA1 || got[1].c !== 8'hB2 || got[2].c !== 8'hC3) begin
      errors++;
      $display("FAIL order_abc: got %0d entries exp a1,b2,c3 in order", got.size());
    end
  endtask

  task automatic test_kill();
    logic off;
    got.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 64'h1111;
    tick();
    in_ctrl = 8'h22; in_data = 64'h2222;
    tick();
    in_ctrl = 8'h33; in_data = 64'h3333; kill = 1'b1;
    #1;
    vectors++;
    if (dut_vec !== mdl_out()) begin
      errors++;
      $display("FAIL kill_pre: got %h exp %h", dut_vec, mdl_out());
    end
    tick();
    kill = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h00, 64'h1111}) begin
      errors++;
      $display("FAIL kill_head: got %h exp %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'h00, 64'h1111});
    end
    out_ready = 1'b1;
    off = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = off;
      #1;
      vectors++;
      if (dut_vec !== mdl_out()) begin
        errors++;
        $display("FAIL kill_drain[%0d]: got %h exp %h", i, dut_vec, mdl_out());
      end
      if (in_valid && mdl_rdy()) off = 1'b0;
      tick();
    end
    vectors++;
`ifdef PIPE_STAGE_SKID_EN
    if (got.size() != 3 || got[0] !== {8'h00, 64'h1111} || got[1] !== {8'h00, 64'h2222} || got[2] !== {8'h33, 64'h3333}) begin
`else
    if (got.size() != 2 || got[0] !== {8'h00, 64'h1111} || got[1] !== {8'h33, 64'h3333}) begin
`endif
      errors++;
      $display("FAIL kill_sequence: got %0d entries, first ctrl %h", got.size(), got.size() > 0 ? got[0].c : 8'hxx);
    end
    // kill alongside an accept must leave the incoming entry intact
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h44; in_data = 64'h4444;
    tick();
`ifndef PIPE_STAGE_SKID_EN
    out_ready = 1'b1;
`endif
    in_ctrl = 8'h55; in_data = 64'h5555; kill = 1'b1;
    tick();
    idle();
    out_ready = 1'b1;
    #1;
    vectors++;
`ifdef PIPE_STAGE_SKID_EN
    if ({out_ctrl, out_data, occupancy} !== {8'h00, 64'h4444, 2'd2}) begin
`else
    if ({out_ctrl, out_data, occupancy} !== {8'h55, 64'h5555, 2'd1}) begin
`endif
      errors++;
      $display("FAIL kill_with_accept: got %h", {out_ctrl, out_data, occupancy});
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (dut_vec !== mdl_out()) begin
        errors++;
        $display("FAIL kill_accept_drain[%0d]: got %h exp %h", i, dut_vec, mdl_out());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_flush = $urandom_range(0, 7) == 0;
      in_cond_en = $urandom_range(0, 3) == 0;
      in_cond_pass = $urandom_range(0, 1) == 1;
      kill = $urandom_range(0, 9) == 0;
      in_ctrl = CW'($urandom);
      in_data = {$urandom, $urandom};
      #1;
      vectors++;
      if (dut_vec !== mdl_out()) begin
        errors++;
        $display("FAIL random[%0d]: got %h exp %h", i, dut_vec, mdl_out());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h66; in_data = 64'h6666;
    tick();
    in_ctrl = 8'h67; in_data = 64'h6767;
    tick();
    idle();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, occupancy, out_ctrl, out_data} !== {1'b0, 2'd0, {CW{1'b0}}, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: got %h exp 0", {out_valid, occupancy, out_ctrl, out_data});
    end
    sb.delete();
    last_d = '0;
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (dut_vec !== mdl_out()) begin
      errors++;
      $display("FAIL after_async_reset: got %h exp %h", dut_vec, mdl_out());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_cond();
    test_backpressure();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, default 64, payload width; payload is retained through flush and kill.
REQ-002 Parameter: CTRL_W, default 8, control width; control is zeroed on bubble, flush or kill.
REQ-003 Parameter: COND_IDX, default 0, control bit gated by the conditional-write qualifier.
REQ-004 Port: clock, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high reset.
REQ-006 Port: in_valid, input, 1, upstream entry present.
REQ-007 Port: in_ready, output, 1, stage accepts an entry this cycle.
REQ-008 Port: in_flush, input, 1, incoming entry is flushed.
REQ-009 Port: in_cond_en, input, 1, incoming entry is a conditional write.
REQ-010 Port: in_cond_pass, input, 1, condition result for a conditional write.
REQ-011 Port: in_ctrl, input, CTRL_W, incoming control bits.
REQ-012 Port: in_data, input, DATA_W, incoming payload.
REQ-013 Port: kill, input, 1, zero the control of every held entry.
REQ-014 Port: out_valid, output, 1, head entry present.
REQ-015 Port: out_ready, input, 1, downstream consumes the head entry.
REQ-016 Port: out_ctrl, output, CTRL_W, head control; all zeros whenever out_valid=0.
REQ-017 Port: out_data, output, DATA_W, head payload; holds its last value when out_valid=0.
REQ-018 Port: occupancy, output, 2, number of held entries (0..2).

Function
REQ-019 Accept occurs when in_valid=1 and in_ready=1; pop occurs when out_valid=1 and out_ready=1.
REQ-020 The stored control SHALL be 0 if in_flush=1 on accept; otherwise it SHALL be in_ctrl.
REQ-021 On accept with in_cond_en=1, in_flush=0 and in_cond_pass=0, the stored control SHALL have bit COND_IDX cleared, with all other bits taken from in_ctrl.
REQ-022 A flushed entry SHALL still occupy a slot, assert out_valid and carry in_data unchanged.
REQ-023 Latency SHALL be one cycle: an entry accepted at edge N is visible on out_* after edge N when the stage was empty.
REQ-024 Entries SHALL leave in acceptance order.
REQ-025 While out_valid=1 and out_ready=0, the head entry (out_ctrl, out_data) SHALL be held unchanged.
REQ-026 kill=1 SHALL zero the control of all entries held before the edge; their payload and valid state are kept.
REQ-027 Under a simultaneous kill and accept, the incoming entry SHALL follow REQ-020/021 only and SHALL NOT be affected by kill.
REQ-028 Under a simultaneous pop and accept, occupancy SHALL be unchanged.
REQ-029 in_valid=1 while in_ready=0 SHALL have no effect.

Reset
REQ-030 While reset=1: occupancy=0, out_valid=0, out_ctrl=0, out_data=0, and all internal entries are cleared.
REQ-031 in_ready SHALL be 1 during reset and on the first edge after reset is released.
REQ-032 A reset asserted mid-operation SHALL discard held entries immediately, without waiting for a clock edge.

Configuration
REQ-033 Macro PIPE_STAGE_SKID_EN selects the buffering mode.
REQ-034 With PIPE_STAGE_SKID_EN defined: the stage has two entries; in_ready is a registered signal equal to (occupancy<2) with no combinational path from out_ready; occupancy ranges 0..2.
REQ-035 With PIPE_STAGE_SKID_EN undefined: the stage has one entry; in_ready = (occupancy==0) | out_ready, combinationally; occupancy never exceeds 1.

Verification
REQ-036 Reset, then in_valid=1, in_ctrl=0x5A, in_data=0x1234 for one cycle, out_ready=1 -> out_valid=1, out_ctrl=0x5A, out_data=0x1234 one cycle later, followed by occupancy=0.
REQ-037 Accept with in_flush=1, in_ctrl=0xFF, in_data=0xBEEF -> out_valid=1, out_ctrl=0x00, out_data=0xBEEF.
REQ-038 in_cond_en=1, in_cond_pass=0, in_ctrl=0x03, COND_IDX=0 -> out_ctrl=0x02; repeat with in_cond_pass=1 -> out_ctrl=0x03.
REQ-039 SKID mode: out_ready=0 while three entries A, B, C are offered -> A and B are accepted, occupancy=2, in_ready=0 and C is held upstream; release out_ready -> A, B, C are output in order.
REQ-040 Two entries held with ctrl 0x11 and 0x22, kill=1 pulsed together with accept of 0x33 -> held entries output ctrl 0x00 with their original data, and the third entry outputs 0x33.
REQ-041 reset asserted asynchronously mid-cycle with occupancy=2 -> out_valid=0 and occupancy=0 before the next clock edge.
